// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32 control FSM with memory wait timeout and retire counter
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             JalrSel,
  output logic             Jump,
  output logic [1:0]       ALUOp,
  output logic [1:0]       RWSel,
  output logic             Halt,
  output logic             Fault,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] RetiredCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_HALT = 7'b0000000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_FAULT  = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              alu_src_dec;
  logic [1:0]        alu_op_dec;

  assign State   = state;
  // Expiry only matters when the access is still stalling; a late MemReady wins.
  assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) && !MemReady;

  // ALU source/op as the single-cycle decoder would produce them for this opcode
  always_comb begin
    alu_src_dec = 1'b0;
    alu_op_dec  = 2'b00;
    case (Opcode)
      OP_R:    begin alu_src_dec = 1'b0; alu_op_dec = 2'b10; end
      OP_IMM:  begin alu_src_dec = 1'b1; alu_op_dec = 2'b10; end
      OP_JALR: begin alu_src_dec = 1'b1; alu_op_dec = 2'b10; end
      OP_LW:   begin alu_src_dec = 1'b1; alu_op_dec = 2'b00; end
      OP_SW:   begin alu_src_dec = 1'b1; alu_op_dec = 2'b00; end
      OP_BR:   begin alu_src_dec = 1'b0; alu_op_dec = 2'b01; end
      OP_LUI:  begin alu_src_dec = 1'b1; alu_op_dec = 2'b11; end
      default: begin alu_src_dec = 1'b0; alu_op_dec = 2'b00; end
    endcase
  end

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (MemReady)     next_state = S_DECODE;
        else if (timeout) next_state = S_FAULT;
      end
      S_DECODE: begin
        case (Opcode)
          OP_HALT: next_state = S_HALTED;
          OP_R, OP_LW, OP_SW, OP_BR, OP_IMM, OP_JAL, OP_JALR, OP_LUI:
                   next_state = S_EXEC;
          default: next_state = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (Opcode)
          OP_BR, OP_JAL, OP_JALR: next_state = S_FETCH;
          OP_LW, OP_SW:           next_state = S_MEM;
          default:                next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (MemReady)     next_state = (Opcode == OP_LW) ? S_WB : S_FETCH;
        else if (timeout) next_state = S_FAULT;
      end
      S_WB:     next_state = S_FETCH;
      S_HALTED: next_state = S_HALTED;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FAULT;
    endcase
  end

  // Control outputs decoded from state and opcode; everything held low during reset
  always_comb begin
    PCWrite  = 1'b0; IRWrite  = 1'b0; IorD     = 1'b0; ALUSrc = 1'b0;
    MemtoReg = 1'b0; RegWrite = 1'b0; MemRead  = 1'b0; MemWrite = 1'b0;
    Branch   = 1'b0; JalrSel  = 1'b0; Jump     = 1'b0;
    ALUOp    = 2'b00; RWSel   = 2'b00; Halt    = 1'b0; Fault  = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = MemReady;
        end
        S_EXEC: begin
          ALUSrc = alu_src_dec;
          ALUOp  = alu_op_dec;
          if (Opcode == OP_BR) begin
            Branch  = 1'b1;
            PCWrite = 1'b1;
          end else if (Opcode == OP_JAL || Opcode == OP_JALR) begin
            Jump     = 1'b1;
            RegWrite = 1'b1;
            RWSel    = 2'b01;
            PCWrite  = 1'b1;
            JalrSel  = (Opcode == OP_JALR);
          end
        end
        S_MEM: begin
          IorD = 1'b1;
          if (Opcode == OP_LW) begin
            MemRead = 1'b1;
          end else begin
            MemWrite = 1'b1;
            PCWrite  = MemReady;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          MemtoReg = (Opcode == OP_LW);
          ALUSrc   = alu_src_dec;
          ALUOp    = alu_op_dec;
        end
        S_HALTED: Halt  = 1'b1;
        S_FAULT:  Fault = 1'b1;
        default: ;
      endcase
    end
  end

  // State register, memory wait counter and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      RetiredCnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !MemReady)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      RetiredCnt <= RetiredCnt + CNT_W'(PCWrite);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  Opcode;
  logic        MemReady;
  logic        PCWrite, IRWrite, IorD, ALUSrc, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, Branch, JalrSel, Jump, Halt, Fault;
  logic [1:0]  ALUOp, RWSel;
  logic [2:0]  State;
  logic [31:0] RetiredCnt;
  logic [16:0] dut_ctl;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .JalrSel(JalrSel), .Jump(Jump), .ALUOp(ALUOp), .RWSel(RWSel),
    .Halt(Halt), .Fault(Fault), .State(State), .RetiredCnt(RetiredCnt)
  );

  always #5 clk = ~clk;

  assign dut_ctl = {PCWrite, IRWrite, IorD, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                    Branch, JalrSel, Jump, ALUOp, RWSel, Halt, Fault};

  localparam logic [16:0] PCW  = 17'h10000;
  localparam logic [16:0] IRW  = 17'h08000;
  localparam logic [16:0] IORD = 17'h04000;
  localparam logic [16:0] ASRC = 17'h02000;
  localparam logic [16:0] M2R  = 17'h01000;
  localparam logic [16:0] REGW = 17'h00800;
  localparam logic [16:0] MRD  = 17'h00400;
  localparam logic [16:0] MWR  = 17'h00200;
  localparam logic [16:0] BR   = 17'h00100;
  localparam logic [16:0] JALR = 17'h00080;
  localparam logic [16:0] JMP  = 17'h00040;
  localparam logic [16:0] A01  = 17'h00010;
  localparam logic [16:0] A10  = 17'h00020;
  localparam logic [16:0] A11  = 17'h00030;
  localparam logic [16:0] RW01 = 17'h00004;
  localparam logic [16:0] HLT  = 17'h00002;
  localparam logic [16:0] FLT  = 17'h00001;
  localparam logic [16:0] FE   = MRD | IRW;

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [16:0] ctl;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void add(logic r, logic [6:0] op, logic rdy, logic [2:0] st,
                              logic [16:0] ctl, int unsigned cnt);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int row, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
  endtask

  initial begin
    bit found;

    // reset held
    add(0, 7'h00, 0, 0, 0, 0);
    // R-type add
    add(1, 7'h33, 1, 0, FE, 0);
    add(1, 7'h33, 1, 1, 0, 0);
    add(1, 7'h33, 1, 2, A10, 0);
    add(1, 7'h33, 1, 4, PCW | REGW | A10, 0);
    // LW with three wait cycles in MEM
    add(1, 7'h03, 1, 0, FE, 1);
    add(1, 7'h03, 1, 1, 0, 1);
    add(1, 7'h03, 1, 2, ASRC, 1);
    add(1, 7'h03, 0, 3, IORD | MRD, 1);
    add(1, 7'h03, 0, 3, IORD | MRD, 1);
    add(1, 7'h03, 0, 3, IORD | MRD, 1);
    add(1, 7'h03, 1, 3, IORD | MRD, 1);
    add(1, 7'h03, 1, 4, PCW | REGW | M2R | ASRC, 1);
    // JALR
    add(1, 7'h67, 1, 0, FE, 2);
    add(1, 7'h67, 1, 1, 0, 2);
    add(1, 7'h67, 1, 2, PCW | ASRC | A10 | JMP | REGW | RW01 | JALR, 2);
    // SW
    add(1, 7'h23, 1, 0, FE, 3);
    add(1, 7'h23, 1, 1, 0, 3);
    add(1, 7'h23, 1, 2, ASRC, 3);
    add(1, 7'h23, 1, 3, IORD | MWR | PCW, 3);
    // branch
    add(1, 7'h63, 1, 0, FE, 4);
    add(1, 7'h63, 1, 1, 0, 4);
    add(1, 7'h63, 1, 2, PCW | BR | A01, 4);
    // LUI
    add(1, 7'h37, 1, 0, FE, 5);
    add(1, 7'h37, 1, 1, 0, 5);
    add(1, 7'h37, 1, 2, ASRC | A11, 5);
    add(1, 7'h37, 1, 4, PCW | REGW | ASRC | A11, 5);
    // SW interrupted by reset during MEM
    add(1, 7'h23, 1, 0, FE, 6);
    add(1, 7'h23, 1, 1, 0, 6);
    add(1, 7'h23, 1, 2, ASRC, 6);
    add(1, 7'h23, 0, 3, IORD | MWR, 6);
    add(0, 7'h23, 0, 3, 0, 6);
    // fetch timeout with MEM_TIMEOUT=4
    add(1, 7'h23, 0, 0, MRD, 0);
    add(1, 7'h23, 0, 0, MRD, 0);
    add(1, 7'h23, 0, 0, MRD, 0);
    add(1, 7'h23, 0, 0, MRD, 0);
    add(1, 7'h23, 0, 6, FLT, 0);
    add(1, 7'h23, 1, 6, FLT, 0);
    // reset out of FAULT, then halt
    add(0, 7'h00, 1, 6, 0, 0);
    add(1, 7'h00, 1, 0, FE, 0);
    add(1, 7'h00, 1, 1, 0, 0);
    add(1, 7'h00, 1, 5, HLT, 0);
    add(1, 7'h00, 1, 5, HLT, 0);
    // reset out of HALTED, then illegal opcode
    add(0, 7'h7f, 1, 5, 0, 0);
    add(1, 7'h7f, 1, 0, FE, 0);
    add(1, 7'h7f, 1, 1, 0, 0);
    add(1, 7'h7f, 1, 6, FLT, 0);
    add(1, 7'h7f, 1, 6, FLT, 0);

    reset_n = 1'b0; Opcode = 7'h00; MemReady = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_n  = vecs[i].rst_n;
      Opcode   = vecs[i].op;
      MemReady = vecs[i].rdy;
      #1;
      check("state", i, 64'(State), 64'(vecs[i].st));
      check("ctl", i, 64'(dut_ctl), 64'(vecs[i].ctl));
      check("retired", i, 64'(RetiredCnt), 64'(vecs[i].cnt));
      check("rd_wr_excl", i, 64'(MemRead & MemWrite), 64'(0));
    end

    // MEM timeout: LW stalls four cycles in MEM and faults
    @(negedge clk);
    reset_n = 1'b0; Opcode = 7'h03; MemReady = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      #1;
      if (State == 3'd3) found = 1'b1;
    end
    check("reach_mem", 100, 64'(found), 64'(1));
    MemReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    check("mem_wait_last", 101, 64'(State), 64'(3));
    @(negedge clk);
    #1;
    check("mem_timeout_state", 102, 64'(State), 64'(6));
    check("mem_timeout_ctl", 102, 64'(dut_ctl), 64'(FLT));
    check("mem_timeout_retired", 102, 64'(RetiredCnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: consecutive not-ready cycles in a memory wait state before the fault state is entered.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Opcode  input  7  opcode field of the instruction register, valid from DECODE onward.
REQ-006 MemReady  input  1  memory handshake: the access presented this cycle completes this cycle.
REQ-007 PCWrite, IRWrite, IorD  output  1 each  PC update strobe, instruction register load strobe, and memory address select (0 = PC, 1 = ALU result).
REQ-008 ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, Jump  output  1 each  datapath controls, same meaning as the single-cycle decoder.
REQ-009 ALUOp  output  2  encoding: 00 = LW/SW, 01 = branch, 10 = R-type/OP-IMM/JALR, 11 = LUI.
REQ-010 RWSel  output  2  register write source: 00 = ALU/memory, 01 = PC+4; bit 1 is always 0.
REQ-011 Halt, Fault  output  1 each  sticky status flags.
REQ-012 State  output  3  current state encoding; RetiredCnt  output  CNT_W  count of retired instructions.

Function
REQ-013 State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5, FAULT=6; code 7 is unreachable and, if ever entered, transitions to FAULT.
REQ-014 All control outputs are a combinational function of State and Opcode; only the state register, the wait counter and RetiredCnt are registered.
REQ-015 FETCH behaviour:
- Drives MemRead=1, IorD=0.
- If MemReady=1: drives IRWrite=1 and transitions to DECODE.
- Otherwise remains in FETCH.
REQ-016 DECODE behaviour, no outputs asserted:
- Opcode 0000000: transition to HALTED.
- Opcode in {0110011, 0000011, 0100011, 1100011, 0010011, 1101111, 1100111, 0110111}: transition to EXEC.
- Any other opcode: transition to FAULT.
REQ-017 EXEC drives ALUSrc and ALUOp exactly per the single-cycle decoder table for the decoded Opcode.
REQ-018 EXEC, branch (1100011): drives Branch=1 and PCWrite=1, then transitions to FETCH; the datapath qualifies the PC update with the compare result.
REQ-019 EXEC, JAL or JALR: drives Jump=1, RegWrite=1, RWSel=01, PCWrite=1, and JalrSel=1 for JALR only, then transitions to FETCH.
REQ-020 EXEC, LW or SW: transitions to MEM.
REQ-021 EXEC, R-type, OP-IMM or LUI: transitions to WB.
REQ-022 MEM behaviour:
- Drives IorD=1; drives MemRead=1 for LW, MemWrite=1 for SW.
- Holds until MemReady=1.
- On completion, LW transitions to WB; SW drives PCWrite=1 and transitions to FETCH.
REQ-023 WB behaviour:
- Drives RegWrite=1 and PCWrite=1 (PC+4), then transitions to FETCH.
- Drives MemtoReg=1 for LW; ALUSrc and ALUOp are held at their EXEC values.
REQ-024 Instruction latency with zero memory wait: branch/JAL/JALR 3 cycles, R-type/OP-IMM/LUI 4, SW 4, LW 5.
REQ-025 Wait counter:
- Increments each cycle spent in FETCH or MEM with MemReady=0.
- Clears on any state change.
- If it equals MEM_TIMEOUT-1 while MemReady=0, the next state is FAULT.
- A MemReady=1 in that same cycle completes the access normally.
REQ-026 RetiredCnt increments by 1 in every cycle where PCWrite=1, wrapping modulo 2^CNT_W.
REQ-027 HALTED and FAULT are absorbing states: all control outputs are 0; Halt=1 in HALTED only, Fault=1 in FAULT only.
REQ-028 MemRead and MemWrite are never asserted in the same cycle; PCWrite is asserted at most once per instruction.

Reset
REQ-029 When reset_n=0 at a rising edge of clk, State becomes FETCH and the wait counter and RetiredCnt become 0, regardless of the current state, including mid-MEM, HALTED and FAULT.
REQ-030 While reset_n=0, all control outputs, Halt and Fault are forced to 0.
REQ-031 On the first cycle after reset_n rises, the block is in FETCH with MemRead=1.

Verification
REQ-032 Scenario, R-type: reset, then add (0110011) with MemReady held at 1 -> state sequence 0,1,2,4,0; RegWrite=1 only in WB; RetiredCnt=1.
REQ-033 Scenario, load with wait: LW with MemReady low for 3 cycles in MEM -> MEM lasts 4 cycles, followed by WB with MemtoReg=1 and RegWrite=1; total 8 cycles; RetiredCnt=1.
REQ-034 Scenario, jump and store: JALR followed by SW -> JALR retires in 3 cycles with JalrSel=1 and RWSel=01; SW asserts MemWrite for exactly 1 cycle; RetiredCnt=2.
REQ-035 Scenario, fetch timeout: MEM_TIMEOUT=4 with MemReady held at 0 in FETCH -> State=6 and Fault=1 after the 4th cycle; both hold until reset.
REQ-036 Scenario, halt and bad opcode: opcode 0000000 -> State=5 and Halt=1 with no further PCWrite; opcode 1111111 -> State=6.
REQ-037 Scenario, reset mid-operation: reset_n pulsed low during MEM of an SW -> MemWrite drops in the reset cycle; afterwards State=0 and RetiredCnt=0.
